// File: rtl/sap_pkg.sv
// sap_pkg: shared opcodes, T-state encoding and width helper for the sap_core CPU.
package sap_pkg;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPC_W-1:0] OP_STA = 4'h4;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
   localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
   localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

   // Operand/address width left over once the opcode field is removed.
   function automatic int addr_w(input int data_w);
      return data_w - OPC_W;
   endfunction

endpackage

// File: rtl/sap_ram.sv
// sap_ram: single-port synchronous-read program/data memory with a host write
// port that takes priority over the core write. Contents are never reset.
module sap_ram
   import sap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              core_we,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] rd_data,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_q;

   // Host write wins over a same-cycle core write; read is registered every clock.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem_q[prog_addr] <= prog_data;
      end else if (core_we) begin
         mem_q[addr] <= core_wdata;
      end
      rd_q <= mem_q[addr];
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/sap_core.sv
// sap_core: parametrised SAP-style accumulator CPU with variable-length
// instructions, clock enable and a host program-load port.
// Optional macro SAP_STEP_EN adds step_mode/step single-instruction stepping.
//
// state | meaning
// T0    | MAR <= PC (waits here when halted or when stepping is not released)
// T1    | IR <= MEM[MAR], PC <= PC+1
// T2    | decode: load MAR with operand, or finish a 3-cycle instruction
// T3    | memory data phase of LDA/ADD/SUB/STA
// T4    | ALU writeback of ADD/SUB
module sap_core
   import sap_pkg::*;
#(
   parameter  int DATA_W = 8,
   localparam int ADDR_W = addr_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
`ifdef SAP_STEP_EN
   input  logic              step_mode,
   input  logic              step,
`endif
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg
);

   tstate_e           t_q, t_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              halted_q, halted_d;

   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic              run_ok;

   logic [OPC_W-1:0]  opcode;
   logic [ADDR_W-1:0] operand;
   logic              is_sub;
   logic [DATA_W-1:0] b_op;
   logic [DATA_W:0]   alu_sum;

`ifdef SAP_STEP_EN
   assign run_ok = ~step_mode | step;
`else
   assign run_ok = 1'b1;
`endif

   assign opcode  = ir_q[DATA_W-1:ADDR_W];
   assign operand = ir_q[ADDR_W-1:0];

   // SUB is A + ~B + 1, so carry-out set means no borrow.
   assign is_sub  = (opcode == OP_SUB);
   assign b_op    = is_sub ? ~b_q : b_q;
   assign alu_sum = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};

   // Next-state and datapath decode; nothing moves without ce or once halted.
   always_comb begin
      t_d         = t_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      ir_d        = ir_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      z_d         = z_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      halted_d    = halted_q;
      ram_we      = 1'b0;
      if (ce && !halted_q) begin
         case (t_q)
            T0: begin
               if (run_ok) begin
                  mar_d = pc_q;
                  t_d   = T1;
               end
            end
            T1: begin
               ir_d = ram_rdata;
               pc_d = pc_q + ADDR_W'(1);
               t_d  = T2;
            end
            T2: begin
               t_d = T0;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     mar_d = operand;
                     t_d   = T3;
                  end
                  OP_LDI: a_d = {{OPC_W{1'b0}}, operand};
                  OP_JMP: pc_d = operand;
                  OP_JC:  if (c_q) pc_d = operand;
                  OP_JZ:  if (z_q) pc_d = operand;
                  OP_OUT: begin
                     out_data_d  = a_q;
                     out_valid_d = 1'b1;
                  end
                  OP_HLT: halted_d = 1'b1;
                  default: ;
               endcase
            end
            T3: begin
               t_d = T0;
               case (opcode)
                  OP_LDA: a_d = ram_rdata;
                  OP_ADD, OP_SUB: begin
                     b_d = ram_rdata;
                     t_d = T4;
                  end
                  OP_STA: ram_we = 1'b1;
                  default: ;
               endcase
            end
            T4: begin
               a_d = alu_sum[DATA_W-1:0];
               c_d = alu_sum[DATA_W];
               z_d = (alu_sum[DATA_W-1:0] == '0);
               t_d = T0;
            end
            default: t_d = T0;
         endcase
      end
   end

   // Core register bank with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         t_q         <= T0;
         pc_q        <= '0;
         mar_q       <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         t_q         <= t_d;
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         z_q         <= z_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
      end
   end

   // RAM is addressed by next-MAR so read data is ready the state after MAR loads;
   // a reset in the STA write cycle drops the write.
   sap_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk        (clk),
      .addr       (mar_d),
      .core_we    (ram_we & ~rst),
      .core_wdata (a_q),
      .rd_data    (ram_rdata),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data)
   );

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: directed and randomized programs checked against an
// instruction-level reference interpreter.
module tb_sap_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ce = 1'b0;
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
   logic       prog_we = 1'b0;
   logic [3:0] prog_addr = '0;
   logic [7:0] prog_data = '0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halted;
   logic [3:0] pc_dbg;

   sap_core #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
`ifdef SAP_STEP_EN
      .step_mode (step_mode),
      .step      (step),
`endif
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .pc_dbg    (pc_dbg)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   // ---------------- reference interpreter ----------------
   int m_mem[16];
   int m_a, m_c, m_z, m_pc, m_halt;
   int m_outs[$];
   logic [7:0] img[16];

   task automatic model_init();
      for (int i = 0; i < 16; i++) m_mem[i] = int'(img[i]);
      m_a = 0; m_c = 0; m_z = 0; m_pc = 0; m_halt = 0;
      m_outs.delete();
   endtask

   // Executes whole instructions; cyc returns ce cycles used (3/4/5 per instruction).
   task automatic model_run(input int max_instr, output int cyc);
      int op, opd, s;
      cyc = 0;
      for (int i = 0; i < max_instr && m_halt == 0; i++) begin
         op   = m_mem[m_pc] / 16;
         opd  = m_mem[m_pc] % 16;
         m_pc = (m_pc + 1) % 16;
         cyc += (op == 2 || op == 3) ? 5 : (op == 1 || op == 4) ? 4 : 3;
         case (op)
            1: m_a = m_mem[opd];
            2: begin
               s = m_a + m_mem[opd];
               m_c = (s > 255) ? 1 : 0;
               m_a = s % 256;
               m_z = (m_a == 0) ? 1 : 0;
            end
            3: begin
               m_c = (m_a >= m_mem[opd]) ? 1 : 0;
               m_a = (m_a - m_mem[opd] + 256) % 256;
               m_z = (m_a == 0) ? 1 : 0;
            end
            4: m_mem[opd] = m_a;
            5: m_a = opd;
            6: m_pc = opd;
            7: if (m_c != 0) m_pc = opd;
            8: if (m_z != 0) m_pc = opd;
            14: m_outs.push_back(m_a);
            15: m_halt = 1;
            default: ;
         endcase
      end
   endtask

   // ---------------- DUT drivers / monitor ----------------
   int dut_outs[$];
   int tot = 0;
   int halt_at = -1;
   int inj_at = -1;
   logic [3:0] inj_addr = '0;
   logic [7:0] inj_data = '0;

   always @(negedge clk) if (out_valid) dut_outs.push_back(int'(out_data));

   task automatic load_img();
      ce = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; ce = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tot = 0; halt_at = -1;
      dut_outs.delete();
   endtask

   task automatic start_test();
      load_img();
      do_reset();
      model_init();
   endtask

   // Applies n enabled clock edges (ce randomly gapped when rnd=1).
   task automatic run_ce(input int n, input bit rnd);
      int cnt = 0;
      int guard = 0;
      while (cnt < n && guard < 40 * n + 100) begin
         @(negedge clk);
         if (halted && halt_at < 0) halt_at = tot;
         ce = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         prog_we = 1'b0;
         if (ce) begin
            cnt++; tot++;
            if (tot == inj_at) begin
               prog_we = 1'b1; prog_addr = inj_addr; prog_data = inj_data;
            end
         end
         guard++;
      end
      if (cnt < n) check("run_budget", cnt, n);
      @(negedge clk);
      if (halted && halt_at < 0) halt_at = tot;
      ce = 1'b0; prog_we = 1'b0;
   endtask

   task automatic compare_model(input string tag, input int cyc);
      check({tag, "_nout"}, dut_outs.size(), m_outs.size());
      for (int i = 0; i < dut_outs.size() && i < m_outs.size(); i++)
         check($sformatf("%s_out%0d", tag, i), dut_outs[i], m_outs[i]);
      check({tag, "_pc"}, int'(pc_dbg), m_pc);
      check({tag, "_halted"}, int'(halted), m_halt);
      if (m_halt != 0) check({tag, "_halt_cyc"}, halt_at, cyc);
   endtask

   initial begin
      int cyc;
      logic [7:0] prog1[16];
      logic [7:0] prog3[16];

      for (int i = 0; i < 16; i++) begin prog1[i] = 8'h00; prog3[i] = 8'h00; end
      prog1[0] = 8'h55; prog1[1] = 8'h2E; prog1[2] = 8'hE0; prog1[3] = 8'hF0; prog1[14] = 8'h03;
      prog3[0] = 8'h53; prog3[1] = 8'hE0; prog3[2] = 8'h3F; prog3[3] = 8'h85;
      prog3[4] = 8'h61; prog3[5] = 8'hF0; prog3[15] = 8'h01;

      // Test 1: LDI 5, ADD 14, OUT, HLT
      img = prog1;
      start_test();
      check("rst_pc", int'(pc_dbg), 0);
      check("rst_out", int'(out_data), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_halted", int'(halted), 0);
      run_ce(20, 1'b0);
      check("p1_out", int'(out_data), 8);
      check("p1_npulse", dut_outs.size(), 1);
      check("p1_halt_cyc", halt_at, 14);
      check("p1_pc", int'(pc_dbg), 4);
      check("p1_halted", int'(halted), 1);

      // Test 2: SUB flags observed through OUT/JC/JZ
      img = '{8'h53, 8'h3E, 8'hE0, 8'h76, 8'hF0, 8'h00, 8'h88, 8'hF0,
              8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
      start_test();
      model_run(50, cyc);
      run_ce(cyc + 4, 1'b0);
      compare_model("sub_eq", cyc);
      check("sub_eq_pc_c", int'(pc_dbg), 9);
      img[0] = 8'h52;
      start_test();
      model_run(50, cyc);
      run_ce(cyc + 4, 1'b0);
      compare_model("sub_lt", cyc);
      check("sub_lt_ff", (dut_outs.size() > 0) ? dut_outs[0] : -1, 255);
      check("sub_lt_pc_c", int'(pc_dbg), 5);

      // Test 3: countdown loop
      img = prog3;
      start_test();
      model_run(100, cyc);
      run_ce(cyc, 1'b0);
      compare_model("cnt", cyc);
      check("cnt_pc_c", int'(pc_dbg), 6);
      check("cnt_n_c", dut_outs.size(), 3);

      // Test 4: STA/LDA round trip, then host write colliding with the STA write
      img = '{8'h57, 8'h4F, 8'h50, 8'h1F, 8'hE0, 8'hF0, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      start_test();
      run_ce(24, 1'b0);
      check("sta_rt", (dut_outs.size() > 0) ? dut_outs[0] : -1, 7);
      start_test();
      inj_at = 7; inj_addr = 4'd15; inj_data = 8'hA5;
      run_ce(24, 1'b0);
      inj_at = -1;
      check("sta_prog_wins", (dut_outs.size() > 0) ? dut_outs[0] : -1, 8'hA5);

      // Test 5: random ce over program 1; PC wrap over NOP memory
      img = prog1;
      start_test();
      model_run(10, cyc);
      run_ce(cyc, 1'b1);
      compare_model("p1_rce", cyc);
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      start_test();
      run_ce(45, 1'b1);
      check("wrap_pc15", int'(pc_dbg), 15);
      run_ce(3, 1'b1);
      check("wrap_pc0", int'(pc_dbg), 0);
      run_ce(3, 1'b0);
      check("wrap_pc1", int'(pc_dbg), 1);

      // Test 6: reset after a halt and in T3 of ADD; memory survives
      img = prog1;
      start_test();
      run_ce(16, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("rst2_out", int'(out_data), 0);
      check("rst2_halted", int'(halted), 0);
      check("rst2_pc", int'(pc_dbg), 0);
      tot = 0; halt_at = -1; dut_outs.delete();
      run_ce(6, 1'b0);
      check("mid_pc_pre", int'(pc_dbg), 2);
      @(negedge clk); rst = 1'b1; ce = 1'b1;
      @(negedge clk); rst = 1'b0; ce = 1'b0;
      check("mid_pc", int'(pc_dbg), 0);
      check("mid_valid", int'(out_valid), 0);
      tot = 0; halt_at = -1; dut_outs.delete();
      run_ce(16, 1'b1);
      check("mid_rerun_out", (dut_outs.size() == 1) ? dut_outs[0] : -1, 8);
      check("mid_rerun_cyc", halt_at, 14);

`ifdef SAP_STEP_EN
      img = prog3;
      start_test();
      step_mode = 1'b1;
      run_ce(8, 1'b0);
      check("step_wait", int'(pc_dbg), 0);
      step = 1'b1; run_ce(1, 1'b0); step = 1'b0;
      run_ce(8, 1'b0);
      check("step1_pc", int'(pc_dbg), 1);
      step = 1'b1; run_ce(1, 1'b0); step = 1'b0;
      run_ce(8, 1'b0);
      check("step2_pc", int'(pc_dbg), 2);
      check("step2_out", (dut_outs.size() == 1) ? dut_outs[0] : -1, 3);
      step_mode = 1'b0;
      run_ce(80, 1'b0);
      check("step_run_pc", int'(pc_dbg), 6);
`endif

      // Randomized programs against the interpreter
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
         start_test();
         model_run(30, cyc);
         run_ce(cyc, 1'b1);
         compare_model($sformatf("rnd%0d", r), cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sap_core.md
Name: sap_core

Overview:
Parametrised successor to the 8-bit bus CPU. It packages the program counter, memory, A/B registers, adder/subtractor, instruction register and controller into one core.
- Configurable data width; address width derived from it.
- Carry/zero flags with conditional jumps, store-to-memory, load-immediate and an output port.
- Variable-length instructions instead of fixed T-state counts.
- A clock-enable replaces the gated CPU clock.
- A host-side program-load port fills memory.

Parameters:
DATA_W, 8, datapath and memory word width; must be >= 6.
OPC_W, 4, opcode width, fixed at 4; operand width ADDR_W = DATA_W - OPC_W; memory depth 2**ADDR_W.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ce  in  1  clock enable; core state advances only on clk edges with ce=1
prog_we  in  1  host memory write strobe
prog_addr  in  ADDR_W  host write address
prog_data  in  DATA_W  host write data
out_data  out  DATA_W  output register
out_valid  out  1  one-clk pulse when out_data is updated
halted  out  1  core stopped by HLT
pc_dbg  out  ADDR_W  current PC, for display/LEDs

Behaviour:
- Reset:
  - PC, MAR, IR, A, B, C, Z and out_data are 0; out_valid and halted are 0; T-state is T0.
  - Memory contents are not cleared.
  - rst mid-instruction aborts the instruction; any pending memory write is dropped.
- Instruction word: opcode = [DATA_W-1:ADDR_W], operand = [ADDR_W-1:0].
- Fetch, every instruction:
  - T0: MAR<=PC.
  - T1: IR<=MEM[MAR]; PC<=PC+1 mod 2**ADDR_W.
- Execute, after the last listed T-state return to T0:
  - 0 NOP: T2 idle.
  - 1 LDA a: T2 MAR<=a; T3 A<=MEM.
  - 2 ADD a: T2 MAR<=a; T3 B<=MEM; T4 A<=A+B, C<=carry-out, Z<=(sum==0).
  - 3 SUB a: same as ADD with A+~B+1; C=1 means no borrow.
  - 4 STA a: T2 MAR<=a; T3 MEM[MAR]<=A.
  - 5 LDI k: T2 A<=zero-extended k.
  - 6 JMP a: T2 PC<=a.
  - 7 JC a: T2 PC<=a if C=1, else no change.
  - 8 JZ a: same as JC, conditioned on Z.
  - E OUT: T2 out_data<=A; out_valid=1 on the next clk cycle only, independent of ce.
  - F HLT: T2 halted<=1; the core freezes at T0 until rst.
  - 9-D: treated as NOP.
- Cycle counts with ce tied high: NOP/LDI/JMP/JC/JZ/OUT/HLT = 3, LDA/STA = 4, ADD/SUB = 5.
- Only ADD and SUB modify C and Z.
- Memory read is synchronous: MEM output is valid in the T-state after MAR is loaded.
- PC wraps from 2**ADDR_W-1 to 0.
- prog_we writes regardless of ce or halted. If it coincides with an STA write, prog_we wins and the STA write is dropped.
- Host loading is intended while ce=0 or during rst.
- ce=0 holds all core state, including out_valid=0.

Optional Feature:
SAP_STEP_EN
- Defined: adds input ports step_mode (1) and step (1).
  - With step_mode=1, the core waits in T0 until a ce cycle sees step=1, then executes exactly one full instruction and waits at T0 again.
  - With step_mode=0 the core runs continuously.
- Undefined: no extra ports; the core always runs continuously.

Decomposition:
- Package sap_pkg: OPC_W; opcode constants OP_NOP..OP_HLT; T-state enumeration T0..T4; helper function for ADDR_W.
- One sub-module, sap_ram: single-port synchronous-read RAM of DATA_W x 2**ADDR_W, plus a prioritised host write port.

Test Plan:
1. Load [LDI 5, ADD 14, OUT, HLT] with MEM[14]=3 -> out_data=8 with a one-cycle out_valid pulse; halted=1 after 3+5+3+3=14 ce cycles.
2. SUB: A=3, MEM[x]=3 -> A=0, Z=1, C=1. Then A=2, MEM[x]=3 -> A=0xFF, Z=0, C=0. JZ taken in the first case only.
3. Countdown loop [LDI 3; OUT; SUB one; JZ end; JMP 1; end: HLT] -> outputs 3, 2, 1, then halt; PC after HLT=6.
4. STA 15 followed by LDA 15 -> round-trips A; prog_we in the same cycle as the STA write leaves the host value in MEM[15].
5. ce toggled 1/0 randomly over program 1 -> same result as ce tied high; no out_valid pulses while ce=0; PC wrap verified by a NOP-filled memory cycling through 15 -> 0.
6. rst asserted during T3 of ADD -> all registers 0 and T0 on the next cycle; memory preserved; with SAP_STEP_EN, each step pulse advances pc_dbg by one instruction.
